// File: rtl/dec2oct_pkg.sv
// Purpose: shared widths, constants and FSM state type for the binary to
//          decimal-coded-octal converter.
// Contents: digit count, accumulator/power widths, saturation constants, state_t.
package dec2oct_pkg;

  // Six 3-bit octal digits cover a 16-bit input (18 bits, top two always 0).
  localparam int unsigned OCT_DIGITS = 6;
  localparam int unsigned DEC_W      = 16;
  localparam int unsigned OCT_W      = 16;
  localparam int unsigned SHIFT_W    = 3 * OCT_DIGITS;

  // Largest result is 177777 (Dec=65535), which needs 18 bits; 20 leaves margin
  // so the digit product can be added without a carry-out.
  localparam int unsigned ACC_W = 20;

  // Holds the place value up to 100000 for the sixth digit.
  localparam int unsigned POW_W = 17;

  // Step counter: counts 0..OCT_DIGITS-1.
  localparam int unsigned CNT_W = 3;

  // Octal 177777 is out of reach of 16 bits; 27485 is the largest input whose
  // decimal-coded octal form (65535) still fits.
  localparam logic [DEC_W-1:0] MAX_FIT_DEC = 16'd27485;
  localparam logic [OCT_W-1:0] SAT_VAL     = 16'hFFFF;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage : dec2oct_pkg

// File: rtl/decimal_to_octal_if.sv
// Purpose: request/result bundle of the decimal-coded-octal converter.
// Ports: start/Dec from the requester; busy/done/Octal/ovf back from the engine.
// Modports: master = requester side, slave = converter side.
interface decimal_to_octal_if;
  import dec2oct_pkg::*;

  logic             start;
  logic [DEC_W-1:0] Dec;
  logic             busy;
  logic             done;
  logic [OCT_W-1:0] Octal;
  logic             ovf;

  modport master (
    output start,
    output Dec,
    input  busy,
    input  done,
    input  Octal,
    input  ovf
  );

  modport slave (
    input  start,
    input  Dec,
    output busy,
    output done,
    output Octal,
    output ovf
  );

endinterface : decimal_to_octal_if

// File: rtl/oct_digit_mac.sv
// Purpose: one digit step: acc_next = acc + digit*pow, pow_next = pow*10.
// Latency: purely combinational.
// Backpressure: none; evaluated every cycle, the caller decides when to register.
// Ports: digit (3b octal digit), acc/pow (current state), acc_next/pow_next.
module oct_digit_mac
  import dec2oct_pkg::*;
(
  input  logic [2:0]       digit,
  input  logic [ACC_W-1:0] acc,
  input  logic [POW_W-1:0] pow,
  output logic [ACC_W-1:0] acc_next,
  output logic [POW_W-1:0] pow_next
);

  logic [ACC_W-1:0] pow_ext;
  logic [ACC_W-1:0] prod;

  assign pow_ext = ACC_W'(pow);

  // 3 x 17 multiply written as a shift-add over the three digit bits.
  always_comb begin
    prod = '0;
    if (digit[0]) prod = prod + pow_ext;
    if (digit[1]) prod = prod + (pow_ext << 1);
    if (digit[2]) prod = prod + (pow_ext << 2);
  end

  assign acc_next = acc + prod;

  // x10 = x8 + x2. After the sixth step this wraps in 17 bits, but that value
  // is never used: the accumulator is already final by then.
  assign pow_next = (pow << 3) + (pow << 1);

endmodule : oct_digit_mac

// File: rtl/decimal_to_octal.sv
// Purpose: iterative binary -> decimal-coded-octal converter, one octal digit per clock.
// Latency: done pulses 6 cycles after the accepting edge; one conversion per 7 cycles.
// Backpressure: start is only sampled while busy=0; starts during a conversion are dropped.
// Ports: clk, rst_n (async active-low), bus (slave side: start/Dec in,
//        busy/done/Octal/ovf out).
module decimal_to_octal
  import dec2oct_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  decimal_to_octal_if.slave    bus
);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic [SHIFT_W-1:0] shift_q, shift_d;
  logic [ACC_W-1:0]   acc_q,   acc_d;
  logic [POW_W-1:0]   pow_q,   pow_d;
  logic [OCT_W-1:0]   octal_q, octal_d;
  logic               ovf_q,   ovf_d;
  logic               done_q,  done_d;

  logic [ACC_W-1:0]   acc_next;
  logic [POW_W-1:0]   pow_next;
  logic               last_step;
  logic               fits;

  oct_digit_mac u_mac (
    .digit    (shift_q[2:0]),
    .acc      (acc_q),
    .pow      (pow_q),
    .acc_next (acc_next),
    .pow_next (pow_next)
  );

  assign last_step = (cnt_q == CNT_W'(OCT_DIGITS - 1));

  // The final sum fits in 16 bits exactly when nothing is set above bit 15.
  assign fits = (acc_next[ACC_W-1:OCT_W] == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    acc_d   = acc_q;
    pow_d   = pow_q;
    octal_d = octal_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Also reached in the done cycle, so a held start chains conversions.
        if (bus.start) begin
          shift_d = SHIFT_W'(bus.Dec);
          acc_d   = '0;
          pow_d   = POW_W'(1);
          cnt_d   = '0;
          state_d = RUN;
        end
      end

      RUN: begin
        shift_d = shift_q >> 3;
        acc_d   = acc_next;
        pow_d   = pow_next;
        if (last_step) begin
          // Result is taken from the mac output so the sixth digit counts.
          octal_d = fits ? acc_next[OCT_W-1:0] : SAT_VAL;
          ovf_d   = ~fits;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      acc_q   <= '0;
      pow_q   <= '0;
      octal_q <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      acc_q   <= acc_d;
      pow_q   <= pow_d;
      octal_q <= octal_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy  = (state_q == RUN);
  assign bus.done  = done_q;
  assign bus.Octal = octal_q;
  assign bus.ovf   = ovf_q;

endmodule : decimal_to_octal

// File: tb/tb_decimal_to_octal.sv
// Purpose: self-checking bench for decimal_to_octal.
// Latency: n/a (bench).
// Backpressure: n/a (bench).
module tb_decimal_to_octal;

  logic clk;
  logic rst_n;

  decimal_to_octal_if bus ();

  decimal_to_octal dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
               name, act, act, exp, exp, $time);
    end
  endtask

  // Reference: octal digits by repeated division, re-read as decimal digits.
  function automatic int unsigned ref_value(input logic [15:0] dec);
    int unsigned v;
    int unsigned p;
    int unsigned r;
    v = dec;
    p = 1;
    r = 0;
    while (v != 0) begin
      r += (v % 8) * p;
      p *= 10;
      v /= 8;
    end
    return r;
  endfunction

  function automatic logic [15:0] ref_octal(input logic [15:0] dec);
    int unsigned r;
    r = ref_value(dec);
    return (r > 65535) ? 16'hFFFF : r[15:0];
  endfunction

  function automatic logic ref_ovf(input logic [15:0] dec);
    return ref_value(dec) > 65535;
  endfunction

  // Transaction-level model: a request is taken when no conversion is
  // outstanding, and the result appears 6 edges later for one cycle.
  int          m_left  = 0;
  logic [15:0] m_dec   = '0;
  logic        m_done  = 1'b0;
  logic [15:0] m_octal = '0;
  logic        m_ovf   = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left  <= 0;
      m_dec   <= '0;
      m_done  <= 1'b0;
      m_octal <= '0;
      m_ovf   <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (m_left == 0) begin
        if (bus.start === 1'b1) begin
          m_left <= 6;
          m_dec  <= bus.Dec;
        end
      end else begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_done  <= 1'b1;
          m_octal <= ref_octal(m_dec);
          m_ovf   <= ref_ovf(m_dec);
        end
      end
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("cyc_busy",  32'(bus.busy),  32'(m_left != 0));
    chk("cyc_done",  32'(bus.done),  32'(m_done));
    chk("cyc_octal", 32'(bus.Octal), 32'(m_octal));
    chk("cyc_ovf",   32'(bus.ovf),   32'(m_ovf));
  end

  task automatic wait_done(output int cyc, output bit seen);
    seen = 1'b0;
    cyc  = 0;
    for (int i = 1; i <= 20 && !seen; i++) begin
      @(negedge clk);
      cyc = i;
      if (bus.done === 1'b1) seen = 1'b1;
    end
  endtask

  // Called at a negedge with the converter idle.
  task automatic run_conv(input string name, input logic [15:0] dec,
                          input logic [15:0] exp_oct, input logic exp_ovf);
    int cyc;
    bit seen;
    bus.start = 1'b1;
    bus.Dec   = dec;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.Dec   = 16'($urandom);
    wait_done(cyc, seen);
    chk({name, "_done_seen"}, 32'(seen), 32'd1);
    chk({name, "_latency"},   32'(cyc),  32'd7);
    chk({name, "_octal"},     32'(bus.Octal), 32'(exp_oct));
    chk({name, "_ovf"},       32'(bus.ovf),   32'(exp_ovf));
  endtask

  task automatic hold_check(input string name, input logic [15:0] exp_oct, input logic exp_ovf);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.Dec = 16'($urandom);
    end
    @(negedge clk);
    chk({name, "_octal"}, 32'(bus.Octal), 32'(exp_oct));
    chk({name, "_ovf"},   32'(bus.ovf),   32'(exp_ovf));
  endtask

  logic [15:0] dir_dec [14];
  logic [15:0] dir_exp [14];
  logic [15:0] bb_dec  [3];
  logic [15:0] bb_exp  [3];

  initial begin
    int  cyc;
    bit  seen;
    int  done_cnt;

    dir_dec = '{16'd127, 16'd261, 16'd377, 16'd489, 16'd545, 16'd621, 16'd757,
                16'd817, 16'd901, 16'd1095, 16'd1148, 16'd1220, 16'd1399, 16'd1473};
    dir_exp = '{16'd177, 16'd405, 16'd571, 16'd751, 16'd1041, 16'd1155, 16'd1365,
                16'd1461, 16'd1605, 16'd2107, 16'd2174, 16'd2304, 16'd2567, 16'd2701};
    bb_dec  = '{16'd8, 16'd64, 16'd512};
    bb_exp  = '{16'd10, 16'd100, 16'd1000};

    bus.start = 1'b0;
    bus.Dec   = '0;
    rst_n     = 1'b1;
    #1 rst_n  = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_busy",  32'(bus.busy),  32'd0);
    chk("reset_done",  32'(bus.done),  32'd0);
    chk("reset_octal", 32'(bus.Octal), 32'd0);
    chk("reset_ovf",   32'(bus.ovf),   32'd0);
    #1 rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 14; i++)
      run_conv($sformatf("dir%0d", dir_dec[i]), dir_dec[i], dir_exp[i], 1'b0);

    // Boundaries.
    run_conv("b_zero",  16'd0,     16'd0,     1'b0);
    run_conv("b_seven", 16'd7,     16'd7,     1'b0);
    run_conv("b_eight", 16'd8,     16'd10,    1'b0);
    run_conv("b_maxfit",16'd27485, 16'd65535, 1'b0);
    run_conv("b_ovf",   16'd27486, 16'hFFFF,  1'b1);
    run_conv("b_full",  16'd65535, 16'hFFFF,  1'b1);
    hold_check("hold_sat", 16'hFFFF, 1'b1);

    run_conv("pre_hold", 16'd1473, 16'd2701, 1'b0);
    hold_check("hold", 16'd2701, 1'b0);

    // start held during busy with a different Dec must be ignored.
    @(negedge clk);
    bus.start = 1'b1;
    bus.Dec   = 16'd100;
    @(posedge clk);
    #1 bus.Dec = 16'd200;
    repeat (3) @(posedge clk);
    #1 bus.start = 1'b0;
    wait_done(cyc, seen);
    chk("ign_done_seen", 32'(seen), 32'd1);
    chk("ign_octal", 32'(bus.Octal), 32'd144);

    // Back-to-back with start held: one result every 7 cycles.
    bus.start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.Dec = bb_dec[i];
      @(posedge clk);
      #1;
      if (i == 2) bus.start = 1'b0;
      bus.Dec = 16'hBEEF;
      wait_done(cyc, seen);
      chk($sformatf("b2b%0d_done_seen", i), 32'(seen), 32'd1);
      chk($sformatf("b2b%0d_period", i),    32'(cyc),  32'd7);
      chk($sformatf("b2b%0d_octal", i),     32'(bus.Octal), 32'(bb_exp[i]));
    end

    // Reset in the middle of a conversion.
    @(negedge clk);
    bus.start = 1'b1;
    bus.Dec   = 16'd1473;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy",  32'(bus.busy),  32'd0);
    chk("abort_done",  32'(bus.done),  32'd0);
    chk("abort_octal", 32'(bus.Octal), 32'd0);
    chk("abort_ovf",   32'(bus.ovf),   32'd0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) done_cnt++;
    end
    chk("abort_no_done", 32'(done_cnt), 32'd0);
    chk("abort_idle",    32'(bus.busy), 32'd0);

    // Converter still works after the abort.
    run_conv("post_abort", 16'd261, 16'd405, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule : tb_decimal_to_octal
